// File: rtl/mips_pkg.sv
// mips_pkg: MIPS opcode/funct constants, ALUControl codes and request kinds
// shared by the control-unit decoder and the instruction encoder.
package mips_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;

    localparam logic [3:0] ALUCTL_ADD  = 4'b0000;
    localparam logic [3:0] ALUCTL_ADDU = 4'b0001;
    localparam logic [3:0] ALUCTL_SUB  = 4'b0010;
    localparam logic [3:0] ALUCTL_SUBU = 4'b0011;
    localparam logic [3:0] ALUCTL_AND  = 4'b0100;
    localparam logic [3:0] ALUCTL_OR   = 4'b0101;
    localparam logic [3:0] ALUCTL_XOR  = 4'b0110;
    localparam logic [3:0] ALUCTL_NOR  = 4'b0111;
    localparam logic [3:0] ALUCTL_SLT  = 4'b1100;
    localparam logic [3:0] ALUCTL_SLTU = 4'b1101;

    typedef enum logic [3:0] {
        KIND_R, KIND_LW, KIND_SW, KIND_BEQ, KIND_BNE,
        KIND_ADDI, KIND_ADDIU, KIND_ANDI, KIND_ORI, KIND_XORI
    } kindE;

    // Returns {legal, funct}
    function automatic logic [6:0] aluctlToFunct(input logic [3:0] aluctl);
        case (aluctl)
            ALUCTL_ADD:  return {1'b1, FUNCT_ADD};
            ALUCTL_ADDU: return {1'b1, FUNCT_ADDU};
            ALUCTL_SUB:  return {1'b1, FUNCT_SUB};
            ALUCTL_SUBU: return {1'b1, FUNCT_SUBU};
            ALUCTL_AND:  return {1'b1, FUNCT_AND};
            ALUCTL_OR:   return {1'b1, FUNCT_OR};
            ALUCTL_XOR:  return {1'b1, FUNCT_XOR};
            ALUCTL_NOR:  return {1'b1, FUNCT_NOR};
            ALUCTL_SLT:  return {1'b1, FUNCT_SLT};
            ALUCTL_SLTU: return {1'b1, FUNCT_SLTU};
            default:     return 7'b0;
        endcase
    endfunction

    // Returns {legal, opcode}
    function automatic logic [6:0] kindToOpcode(input logic [3:0] kind);
        case (kind)
            KIND_R:     return {1'b1, OPC_RTYPE};
            KIND_LW:    return {1'b1, OPC_LW};
            KIND_SW:    return {1'b1, OPC_SW};
            KIND_BEQ:   return {1'b1, OPC_BEQ};
            KIND_BNE:   return {1'b1, OPC_BNE};
            KIND_ADDI:  return {1'b1, OPC_ADDI};
            KIND_ADDIU: return {1'b1, OPC_ADDIU};
            KIND_ANDI:  return {1'b1, OPC_ANDI};
            KIND_ORI:   return {1'b1, OPC_ORI};
            KIND_XORI:  return {1'b1, OPC_XORI};
            default:    return 7'b0;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous flush; pointers carry a wrap bit
// so full and empty are distinguishable without a separate counter.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wrPtr, rdPtr;

    assign empty = wrPtr == rdPtr;
    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign rdata = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push && !full) wrPtr <= wrPtr + (AW+1)'(1);
            if (pop && !empty) rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !clear) mem[wrPtr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: turns abstract operation requests into MIPS machine words,
// buffers them in a FIFO and drains them with a running byte address.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [3:0]  in_aluctl,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [15:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_illegal,
    output logic [7:0]  err_count
);
    logic        full, empty, accept, legal, push, pop, isR;
    logic [6:0]  fn, op;
    logic [31:0] word, headWord;

    always_comb begin
        fn    = aluctlToFunct(in_aluctl);
        op    = kindToOpcode(in_kind);
        isR   = in_kind == KIND_R;
        legal = isR ? fn[6] : op[6];
        word  = isR ? {OPC_RTYPE, in_rs, in_rt, in_rd, 5'b0, fn[5:0]}
                    : {op[5:0], in_rs, in_rt, in_imm};
    end

    // clear blocks acceptance so a same-cycle request is dropped, not queued
    assign in_ready  = !full && !clear;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready && !clear;
    assign out_valid = !empty;
    assign out_instr = empty ? '0 : headWord;

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) fifo (
        .clk(clk), .rst_n(rst_n), .clear(clear), .push(push), .pop(pop),
        .wdata(word), .rdata(headWord), .full(full), .empty(empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_addr    <= BASE_ADDR;
            err_illegal <= 1'b0;
            err_count   <= '0;
        end else if (clear) begin
            out_addr    <= BASE_ADDR;
            err_illegal <= 1'b0;
            err_count   <= '0;
        end else begin
            if (pop) out_addr <= out_addr + 32'd4;
            if (accept && !legal) begin
                err_illegal <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scenarios plus random traffic checked against a
// queue-based reference model of the encoder.
module tb_instr_encoder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 0, rst_n = 0, clear = 0, in_valid = 0, out_ready = 0;
    logic [3:0]  in_kind = 0, in_aluctl = 0;
    logic [4:0]  in_rs = 0, in_rt = 0, in_rd = 0;
    logic [15:0] in_imm = 0;
    logic        in_ready, out_valid, err_illegal;
    logic [31:0] out_instr, out_addr;
    logic [7:0]  err_count;

    int errors = 0, checks = 0;
    logic [31:0] q[$];
    logic [31:0] mAddr = BASE;
    bit          mErr = 0;
    int          mErrCnt = 0;
    int          opcTab[10] = '{0, 35, 43, 4, 5, 8, 9, 12, 13, 14};

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_aluctl(in_aluctl), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err_illegal(err_illegal), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int functOf(input int alu);
        if (alu <= 7) return 32 + alu;
        if (alu == 12) return 42;
        if (alu == 13) return 43;
        return -1;
    endfunction

    task automatic refEncode(output bit lg, output logic [31:0] w);
        int k = in_kind, f = functOf(in_aluctl);
        lg = 0;
        w  = 0;
        if (k == 0 && f >= 0) begin
            lg = 1;
            w  = in_rs * 32'h20_0000 + in_rt * 32'h1_0000 + in_rd * 32'h800 + f;
        end else if (k >= 1 && k <= 9) begin
            lg = 1;
            w  = opcTab[k] * 32'h400_0000 + in_rs * 32'h20_0000 + in_rt * 32'h1_0000 + in_imm;
        end
    endtask

    task automatic modelReset();
        q.delete();
        mAddr   = BASE;
        mErr    = 0;
        mErrCnt = 0;
    endtask

    // Called at posedge+1 with inputs set; checks, clocks, advances the model.
    task automatic doCycle();
        bit acc, pp, lg;
        logic [31:0] w;
        #1;
        chk("in_ready", in_ready, q.size() < DEPTH && !clear);
        chk("out_valid", out_valid, q.size() > 0);
        chk("out_instr", out_instr, q.size() > 0 ? q[0] : 32'h0);
        chk("out_addr", out_addr, mAddr);
        chk("err_illegal", err_illegal, mErr);
        chk("err_count", err_count, mErrCnt);
        refEncode(lg, w);
        acc = in_valid && q.size() < DEPTH && !clear;
        pp  = q.size() > 0 && out_ready && !clear;
        @(posedge clk);
        #1;
        if (clear) modelReset();
        else begin
            if (pp) begin
                void'(q.pop_front());
                mAddr += 4;
            end
            if (acc && lg) q.push_back(w);
            if (acc && !lg) begin
                mErr = 1;
                if (mErrCnt < 255) mErrCnt++;
            end
        end
    endtask

    task automatic setReq(input int kind, input int alu, input int rs, input int rt,
                          input int rd, input int imm);
        in_valid  = 1;
        in_kind   = 4'(kind);
        in_aluctl = 4'(alu);
        in_rs     = 5'(rs);
        in_rt     = 5'(rt);
        in_rd     = 5'(rd);
        in_imm    = 16'(imm);
    endtask

    task automatic randLegal();
        setReq($urandom_range(1, 9), 0, $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 65535));
    endtask

    initial begin
        logic [31:0] head, startAddr;
        #12 rst_n = 1;
        @(posedge clk);
        #1;
        doCycle();
        chk("reset_instr", out_instr, 32'h0);
        chk("reset_addr", out_addr, BASE);

        // 1: single R-type add
        setReq(0, 0, 1, 2, 3, 0);
        doCycle();
        in_valid = 0;
        #1;
        chk("t1_valid", out_valid, 1);
        chk("t1_word", out_instr, 32'h00221820);
        chk("t1_addr", out_addr, 32'h0);
        out_ready = 1;
        doCycle();

        // 2: lw / sw / beq stream from a fresh address
        out_ready = 0;
        clear = 1;
        doCycle();
        clear = 0;
        setReq(1, 0, 29, 8, 0, 4);
        doCycle();
        setReq(2, 0, 29, 8, 0, 8);
        doCycle();
        setReq(3, 0, 1, 2, 0, 16'hFFFF);
        doCycle();
        in_valid  = 0;
        out_ready = 1;
        #1;
        chk("t2_w0", out_instr, 32'h8FA80004);
        chk("t2_a0", out_addr, 32'h0);
        doCycle();
        chk("t2_w1", out_instr, 32'hAFA80008);
        chk("t2_a1", out_addr, 32'h4);
        doCycle();
        chk("t2_w2", out_instr, 32'h1022FFFF);
        chk("t2_a2", out_addr, 32'h8);
        doCycle();
        chk("t2_empty", out_valid, 0);

        // 3: fill with consumer stalled, hold a 5th request, then drain
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            randLegal();
            doCycle();
        end
        #1;
        chk("t3_full_ready", in_ready, 0);
        head = q[0];
        startAddr = mAddr;
        randLegal();
        doCycle();
        doCycle();
        chk("t3_head_stable", out_instr, head);
        chk("t3_depth", q.size(), 4);
        in_valid  = 0;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_drain_addr", out_addr, startAddr + 32'(4 * i));
            doCycle();
        end
        chk("t3_drained", out_valid, 0);

        // 4: illegal requests and saturation
        clear = 1;
        doCycle();
        clear = 0;
        setReq(12, 0, 1, 1, 1, 1);
        doCycle();
        setReq(0, 8, 1, 1, 1, 1);
        doCycle();
        in_valid = 0;
        #1;
        chk("t4_nothing_queued", out_valid, 0);
        chk("t4_err", err_illegal, 1);
        chk("t4_count", err_count, 8'd2);
        setReq(15, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) doCycle();
        chk("t4_saturate", err_count, 8'hFF);

        // 5: clear with a simultaneous request, FIFO half full
        in_valid  = 0;
        out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            randLegal();
            doCycle();
        end
        clear = 1;
        randLegal();
        doCycle();
        clear = 0;
        in_valid = 0;
        #1;
        chk("t5_empty", out_valid, 0);
        chk("t5_addr", out_addr, BASE);
        chk("t5_errs", err_count, 8'h0);
        doCycle();
        chk("t5_not_enqueued", out_valid, 0);

        // 6: asynchronous reset while draining
        for (int i = 0; i < 3; i++) begin
            randLegal();
            doCycle();
        end
        in_valid  = 0;
        out_ready = 1;
        doCycle();
        #3 rst_n = 0;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_addr", out_addr, BASE);
        modelReset();
        out_ready = 0;
        @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk);
        #1;
        doCycle();
        chk("t6_post_instr", out_instr, 32'h0);
        chk("t6_post_err", err_illegal, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            setReq($urandom_range(0, 10), $urandom_range(0, 15), $urandom_range(0, 31),
                   $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 39) == 0);
            doCycle();
        end
        clear = 0;
        in_valid = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
